// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: one outstanding SRAM-like request, one held IF/ID slot, redirects.
// Define IFETCH_ADEL_EN to turn misaligned fetch PCs into address-error bubbles instead of requests.
module inst_fetch_ctrl #(
  parameter int N = 32,
  parameter logic [N-1:0] RESET_PC = 32'hbfc00000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] pc,
  output logic         pc_en,
  output logic         pc_flush,
  output logic [N-1:0] npc,
  output logic         inst_req,
  output logic [N-1:0] inst_addr,
  input  logic         inst_addr_ok,
  input  logic         inst_data_ok,
  input  logic [N-1:0] inst_rdata,
  input  logic         branch_valid,
  input  logic [N-1:0] branch_target,
  input  logic         except_flush,
  input  logic [N-1:0] except_target,
  input  logic         eret,
  input  logic [N-1:0] epc,
  input  logic         id_ready,
  output logic         if_valid,
  output logic [N-1:0] if_pc,
  output logic [N-1:0] if_inst,
  output logic         if_adel
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t       state, state_nx;
  logic         br_pend, br_pend_nx;
  logic         discard, discard_nx;
  logic [N-1:0] br_tgt;
  logic [N-1:0] req_pc;
  logic         redirect;
  logic [N-1:0] redirect_pc;
  logic [N-1:0] seq_pc;
  logic [N-1:0] fetch_addr;
  logic         misaligned;
  logic         load_if;
  logic         adel_load;
  logic         clear_if;

`ifdef IFETCH_ADEL_EN
  assign misaligned = (pc[1:0] != 2'b00);
  assign fetch_addr = pc;
`else
  assign misaligned = 1'b0;
  assign fetch_addr = {pc[N-1:2], 2'b00};
`endif

  assign redirect    = except_flush | eret;
  assign redirect_pc = except_flush ? except_target : epc;
  // A pending branch replaces the sequential successor of the delay-slot request.
  assign seq_pc      = br_pend ? br_tgt : pc + N'(4);

  always_comb begin
    state_nx   = state;
    br_pend_nx = br_pend;
    discard_nx = discard;
    inst_req   = 1'b0;
    inst_addr  = fetch_addr;
    pc_en      = 1'b0;
    pc_flush   = 1'b0;
    npc        = seq_pc;
    load_if    = 1'b0;
    adel_load  = 1'b0;
    clear_if   = 1'b0;
    if (rst) begin
      npc = RESET_PC;
    end else begin
      case (state)
        IDLE: state_nx = REQ;
        REQ: begin
          if (misaligned) begin
            if (!redirect) begin
              state_nx  = HOLD;
              adel_load = 1'b1;
            end
          end else begin
            inst_req = 1'b1;
            if (inst_addr_ok) begin
              state_nx = WAIT;
              if (redirect) begin
                discard_nx = 1'b1;
              end else begin
                pc_en      = 1'b1;
                br_pend_nx = 1'b0;
              end
            end
          end
        end
        WAIT: begin
          // A redirect coinciding with data_ok drops that data just like a recorded discard.
          if (inst_data_ok) begin
            if (discard || redirect) begin
              discard_nx = 1'b0;
              state_nx   = REQ;
            end else begin
              load_if  = 1'b1;
              state_nx = HOLD;
            end
          end else if (redirect) begin
            discard_nx = 1'b1;
          end
        end
        HOLD: begin
          if (redirect || id_ready) begin
            clear_if = 1'b1;
            state_nx = REQ;
          end
        end
        default: state_nx = IDLE;
      endcase
      if (redirect) begin
        pc_flush   = 1'b1;
        npc        = redirect_pc;
        br_pend_nx = 1'b0;
      end else if (branch_valid) begin
        br_pend_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      br_pend  <= 1'b0;
      discard  <= 1'b0;
      br_tgt   <= '0;
      req_pc   <= RESET_PC;
      if_valid <= 1'b0;
      if_pc    <= RESET_PC;
      if_inst  <= '0;
    end else begin
      state   <= state_nx;
      br_pend <= br_pend_nx;
      discard <= discard_nx;
      if (branch_valid && !redirect) br_tgt <= branch_target;
      if (inst_req && inst_addr_ok) req_pc <= pc;
      if (load_if) begin
        if_valid <= 1'b1;
        if_pc    <= req_pc;
        if_inst  <= inst_rdata;
      end else if (adel_load) begin
        if_valid <= 1'b1;
        if_pc    <= pc;
        if_inst  <= '0;
      end else if (clear_if) begin
        if_valid <= 1'b0;
      end
    end
  end

`ifdef IFETCH_ADEL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_adel <= 1'b0;
    end else if (adel_load) begin
      if_adel <= 1'b1;
    end else if (load_if || clear_if) begin
      if_adel <= 1'b0;
    end
  end
`else
  assign if_adel = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: directed redirect/branch/stall scenarios with an SRAM responder
// and a PC register model; expected requests and fetched slots are queued and checked by monitors.
module tb_inst_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'hbfc00000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } fetch_t;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_en;
  logic        pc_flush;
  logic [31:0] npc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        except_flush;
  logic [31:0] except_target;
  logic        eret;
  logic [31:0] epc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;

  logic        aok_en;
  int          data_delay;
  int          checks;
  int          errors;
  logic [31:0] exp_addr_q[$];
  fetch_t      exp_fetch_q[$];

  inst_fetch_ctrl #(.N(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_en(pc_en), .pc_flush(pc_flush), .npc(npc),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .except_flush(except_flush), .except_target(except_target),
    .eret(eret), .epc(epc), .id_ready(id_ready),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_adel(if_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign inst_addr_ok = inst_req & aok_en;

  // PC register model: loads npc on either enable or flush.
  always @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_PC;
    else if (pc_en || pc_flush) pc <= npc;
  end

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    if (addr == 32'hbfc00000) return 32'h24080001;
    return addr ^ 32'ha5a50000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReq();
    int n = 0;
    while (!inst_req && n < 50) begin
      step();
      n++;
    end
    if (!inst_req) checkOutput("wait_inst_req", inst_req, 1);
  endtask

  task automatic waitValid();
    int n = 0;
    while (!if_valid && n < 50) begin
      step();
      n++;
    end
    if (!if_valid) checkOutput("wait_if_valid", if_valid, 1);
  endtask

  // One fetch: grant the request, check the PC update, then optionally let ID take the slot.
  task automatic applyStimulus(input logic [31:0] req_addr, input logic [31:0] fetch_pc,
                               input logic [31:0] npc_exp, input bit accept);
    fetch_t f;
    exp_addr_q.push_back(req_addr);
    if (accept) begin
      f.pc   = fetch_pc;
      f.inst = memWord(req_addr);
      f.adel = 1'b0;
      exp_fetch_q.push_back(f);
    end
    waitReq();
    aok_en = 1'b1;
    #1;
    checkOutput("pc_en_at_accept", pc_en, 1);
    checkOutput("npc_at_accept", npc, npc_exp);
    step();
    aok_en = 1'b0;
    waitValid();
    if (accept) begin
      id_ready = 1'b1;
      step();
      id_ready = 1'b0;
    end
  endtask

  // SRAM responder: data_ok arrives data_delay cycles after the cycle following acceptance.
  initial begin
    bit          accepted;
    bit          pend;
    int          cnt;
    logic [31:0] acc_addr;
    logic [31:0] pend_addr;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    pend         = 1'b0;
    cnt          = 0;
    pend_addr    = '0;
    forever begin
      @(negedge clk);
      accepted = !rst && inst_req && inst_addr_ok;
      acc_addr = inst_addr;
      @(posedge clk);
      #1;
      if (rst) begin
        pend         = 1'b0;
        inst_data_ok = 1'b0;
      end else begin
        if (accepted) begin
          pend      = 1'b1;
          cnt       = data_delay;
          pend_addr = acc_addr;
        end
        if (pend && cnt == 0) begin
          inst_data_ok = 1'b1;
          inst_rdata   = memWord(pend_addr);
          pend         = 1'b0;
        end else begin
          inst_data_ok = 1'b0;
          if (pend) cnt--;
        end
      end
    end
  end

  // Monitors: every accepted request and every slot ID takes is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (inst_req && inst_addr_ok) begin
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_request: got addr %h, expected no request", inst_addr);
        end else begin
          checkOutput("req_addr", inst_addr, exp_addr_q.pop_front());
        end
      end
      if (if_valid && id_ready && !except_flush && !eret) begin
        if (exp_fetch_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_fetch: got pc %h, expected no fetch", if_pc);
        end else begin
          fetch_t f;
          f = exp_fetch_q.pop_front();
          checkOutput("fetch_pc", if_pc, f.pc);
          checkOutput("fetch_inst", if_inst, f.inst);
          checkOutput("fetch_adel", {31'b0, if_adel}, {31'b0, f.adel});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    fetch_t f;
    int n;
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    aok_en        = 1'b0;
    data_delay    = 0;
    id_ready      = 1'b0;
    branch_valid  = 1'b0;
    branch_target = '0;
    except_flush  = 1'b0;
    except_target = '0;
    eret          = 1'b0;
    epc           = '0;

    step();
    step();
    checkOutput("rst_inst_req", inst_req, 0);
    checkOutput("rst_pc_en", pc_en, 0);
    checkOutput("rst_pc_flush", pc_flush, 0);
    checkOutput("rst_if_valid", if_valid, 0);
    checkOutput("rst_if_adel", if_adel, 0);
    checkOutput("rst_if_pc", if_pc, RESET_PC);
    checkOutput("rst_if_inst", if_inst, 0);
    checkOutput("rst_npc", npc, RESET_PC);

    // First fetch with addr_ok already waiting and data_ok on the next cycle.
    aok_en = 1'b1;
    exp_addr_q.push_back(32'hbfc00000);
    f.pc = 32'hbfc00000; f.inst = 32'h24080001; f.adel = 1'b0;
    exp_fetch_q.push_back(f);
    rst = 1'b0;
    step();
    checkOutput("first_inst_req", inst_req, 1);
    checkOutput("first_inst_addr", inst_addr, 32'hbfc00000);
    checkOutput("first_pc_en", pc_en, 1);
    checkOutput("first_npc", npc, 32'hbfc00004);
    step();
    aok_en = 1'b0;
    checkOutput("first_wait_if_valid", if_valid, 0);
    step();
    checkOutput("first_if_valid", if_valid, 1);
    checkOutput("first_if_pc", if_pc, 32'hbfc00000);
    checkOutput("first_if_inst", if_inst, 32'h24080001);

    // ID stalls: the held slot must stay put and no new request may go out.
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("stall_if_valid", if_valid, 1);
      checkOutput("stall_if_pc", if_pc, 32'hbfc00000);
      checkOutput("stall_if_inst", if_inst, 32'h24080001);
      checkOutput("stall_inst_req", inst_req, 0);
    end

    // Branch while holding: delay slot at the current pc, then the target.
    branch_valid  = 1'b1;
    branch_target = 32'hbfc00100;
    id_ready      = 1'b1;
    step();
    branch_valid = 1'b0;
    id_ready     = 1'b0;
    applyStimulus(32'hbfc00004, 32'hbfc00004, 32'hbfc00100, 1'b1);
    applyStimulus(32'hbfc00100, 32'hbfc00100, 32'hbfc00104, 1'b1);

    // Exception while waiting for data: the returned word is dropped.
    data_delay = 2;
    exp_addr_q.push_back(32'hbfc00104);
    waitReq();
    aok_en = 1'b1;
    step();
    aok_en        = 1'b0;
    except_flush  = 1'b1;
    except_target = 32'hbfc00380;
    #1;
    checkOutput("wait_flush_pc_flush", pc_flush, 1);
    checkOutput("wait_flush_npc", npc, 32'hbfc00380);
    checkOutput("wait_flush_pc_en", pc_en, 0);
    step();
    except_flush = 1'b0;
    data_delay   = 0;
    n = 0;
    while (!inst_req && n < 20) begin
      checkOutput("discard_if_valid", if_valid, 0);
      step();
      n++;
    end
    checkOutput("req_after_discard", inst_req, 1);
    applyStimulus(32'hbfc00380, 32'hbfc00380, 32'hbfc00384, 1'b1);

    // ERET beats a same-cycle branch and cancels it.
    eret          = 1'b1;
    epc           = 32'h80001000;
    branch_valid  = 1'b1;
    branch_target = 32'hbfc00200;
    #1;
    checkOutput("eret_pc_flush", pc_flush, 1);
    checkOutput("eret_npc", npc, 32'h80001000);
    checkOutput("eret_pc_en", pc_en, 0);
    step();
    eret         = 1'b0;
    branch_valid = 1'b0;
    applyStimulus(32'h80001000, 32'h80001000, 32'h80001004, 1'b1);
    applyStimulus(32'h80001004, 32'h80001004, 32'h80001008, 1'b1);

    // PC wrap at the top of the address space.
    except_flush  = 1'b1;
    except_target = 32'hfffffffc;
    step();
    except_flush = 1'b0;
    applyStimulus(32'hfffffffc, 32'hfffffffc, 32'h00000000, 1'b1);

    // Flush while holding, with id_ready also high: the slot is killed, not consumed.
    applyStimulus(32'h00000000, 32'h00000000, 32'h00000004, 1'b0);
    except_flush  = 1'b1;
    except_target = 32'hbfc00400;
    id_ready      = 1'b1;
    step();
    except_flush = 1'b0;
    id_ready     = 1'b0;
    checkOutput("hold_flush_if_valid", if_valid, 0);
    checkOutput("hold_flush_inst_req", inst_req, 1);
    checkOutput("hold_flush_inst_addr", inst_addr, 32'hbfc00400);
    applyStimulus(32'hbfc00400, 32'hbfc00400, 32'hbfc00404, 1'b1);

    // Misaligned fetch PC.
    except_flush  = 1'b1;
    except_target = 32'hbfc00002;
    step();
    except_flush = 1'b0;
`ifdef IFETCH_ADEL_EN
    checkOutput("adel_inst_req", inst_req, 0);
    checkOutput("adel_pc_en", pc_en, 0);
    step();
    checkOutput("adel_if_valid", if_valid, 1);
    checkOutput("adel_if_adel", if_adel, 1);
    checkOutput("adel_if_pc", if_pc, 32'hbfc00002);
    checkOutput("adel_if_inst", if_inst, 0);
    except_flush  = 1'b1;
    except_target = 32'hbfc00380;
    step();
    except_flush = 1'b0;
    checkOutput("adel_flush_if_valid", if_valid, 0);
    applyStimulus(32'hbfc00380, 32'hbfc00380, 32'hbfc00384, 1'b1);
`else
    checkOutput("unaligned_inst_req", inst_req, 1);
    checkOutput("unaligned_inst_addr", inst_addr, 32'hbfc00000);
    applyStimulus(32'hbfc00000, 32'hbfc00002, 32'hbfc00006, 1'b1);
`endif

    n = 0;
    while ((exp_addr_q.size() != 0 || exp_fetch_q.size() != 0) && n < 20) begin
      step();
      n++;
    end
    checkOutput("addr_queue_drained", exp_addr_q.size(), 0);
    checkOutput("fetch_queue_drained", exp_fetch_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Fetch sequencer for the MIPS core. It drives the PC register's enable, flush and next-PC inputs, and issues instruction requests on the SRAM-like instruction port. It also holds one fetched instruction for the IF/ID boundary and resolves redirects: exception, ERET, and taken branches with a delay slot. It sits between the PC register, the instruction SRAM bridge, CP0 and the ID stage.

## Interface
Parameters:
- N, 32, address/data width
- RESET_PC, 32'hbfc00000, reset vector; must match the PC register's reset value

Ports:
- clk  in  1  clock
- rst  in  1  reset rst, asynchronous, active-high
- pc  in  N  current PC from the PC register
- pc_en  out  1  PC register enable
- pc_flush  out  1  PC register exception-flush load
- npc  out  N  next PC to the PC register
- inst_req  out  1  request valid, SRAM-like
- inst_addr  out  N  request address
- inst_addr_ok  in  1  address accepted
- inst_data_ok  in  1  read data valid
- inst_rdata  in  N  read data
- branch_valid  in  1  taken-branch pulse from ID
- branch_target  in  N  branch target
- except_flush  in  1  exception pulse from CP0
- except_target  in  N  exception vector
- eret  in  1  ERET pulse
- epc  in  N  ERET return address
- id_ready  in  1  ID accepts the held instruction
- if_valid  out  1  held instruction valid
- if_pc  out  N  PC of the held instruction
- if_inst  out  N  held instruction
- if_adel  out  1  held slot is an address-error bubble (macro only)

## Operation
- States:
  - IDLE: one cycle after reset.
  - REQ: inst_req=1, inst_addr=pc.
  - WAIT: waiting for data_ok.
  - HOLD: if_valid=1.
- Only one request is outstanding at a time.
- Transitions:
  - IDLE->REQ unconditionally.
  - REQ & addr_ok -> WAIT. The accepted pc is latched into req_pc. pc_en=1 with npc=pc+4, or npc=br_tgt if br_pend (br_pend then clears).
  - WAIT & data_ok -> HOLD. if_inst<=inst_rdata and if_pc<=req_pc. If discard=1, the data is dropped instead, discard clears, and the next state is REQ.
  - HOLD & id_ready -> REQ. if_valid clears.
- Redirect priority: except_flush > eret > branch_valid > sequential.
  - except_flush or eret: pc_flush=1, npc=except_target or epc. br_pend clears.
    - In REQ without addr_ok, the new pc is requested next cycle.
    - In REQ with addr_ok, or in WAIT, set discard.
    - In HOLD, if_valid drops next cycle and the next state is REQ, even if id_ready is high.
    - Takes precedence over the sequential pc_en of the same cycle.
  - branch_valid: latches br_tgt<=branch_target and sets br_pend. The PC is not touched yet.
    - The next accepted request is the delay slot, at the current pc.
    - At that request's addr_ok, npc=br_tgt.
    - A second branch_valid while br_pend is set overwrites br_tgt.
- PC arithmetic is modulo 2^N. 0xfffffffc+4 wraps to 0.
- pc_en=0 and pc_flush=0 in every cycle not listed above.

## Timing
- Reset values:
  - inst_req=0, pc_en=0, pc_flush=0, if_valid=0, if_adel=0.
  - if_pc=RESET_PC, if_inst=0, npc=RESET_PC.
  - state=IDLE, br_pend=0, discard=0.
- Reset asserted mid-operation: all of the above apply immediately. An in-flight data_ok arriving after reset is ignored (the state is not WAIT).
- inst_req, inst_addr, pc_en, pc_flush and npc are combinational from state and inputs.
- if_* outputs are registered.
- Minimum latency, addr_ok in the REQ cycle and data_ok the next cycle: if_valid rises 2 cycles after inst_req.
- Best-case sustained throughput is one instruction per 3 cycles.
- Address is allowed to change while inst_req=1 without addr_ok only on a redirect.

## Configuration
- IFETCH_ADEL_EN defined:
  - In REQ, if pc[1:0]!=0, no request is issued (inst_req=0).
  - The block goes straight to HOLD with if_valid=1, if_adel=1, if_pc=pc, if_inst=0.
  - pc_en stays 0; the pipeline's exception raises except_flush.
- IFETCH_ADEL_EN undefined:
  - inst_addr={pc[N-1:2],2'b00}.
  - if_adel is tied to 0.

## Test plan
- Reset release; addr_ok immediate; data_ok next cycle with rdata=0x24080001 -> cycle 1: inst_req=1, inst_addr=0xbfc00000, pc_en=1, npc=0xbfc00004. Then if_valid=1, if_pc=0xbfc00000, if_inst=0x24080001.
- branch_valid target 0xbfc00100 while in HOLD (held instruction at 0xbfc00000, pc=0xbfc00004) -> next fetch address 0xbfc00004 (delay slot), then 0xbfc00100.
- except_flush target 0xbfc00380 in WAIT -> returned data dropped, if_valid stays 0, next inst_addr=0xbfc00380.
- id_ready=0 for 5 cycles in HOLD -> if_valid, if_pc and if_inst stable; inst_req=0 throughout.
- eret (epc=0x80001000) in the same cycle as branch_valid -> pc_flush=1, npc=0x80001000, br_pend=0. Subsequent fetches are 0x80001000, then 0x80001004.
- With IFETCH_ADEL_EN, except_target=0xbfc00002 -> no inst_req; if_valid=1, if_adel=1, if_pc=0xbfc00002.
